// File: rtl/prbs_gen_chk.sv
// PRBS generator with selectable polynomial and a self-synchronising checker.
// The checker seeds from received data, then verifies and tracks lock with a saturating error count.
module prbs_gen_chk #(
    parameter int DATA_W      = 8,
    parameter int ERR_CNT_W   = 16,
    parameter int LOCK_CNT    = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [2:0]           poly_sel,
    input  logic                 inj_err,
    input  logic                 gen_ready,
    output logic                 gen_valid,
    output logic [DATA_W-1:0]    gen_data,
    input  logic                 chk_valid,
    input  logic [DATA_W-1:0]    chk_data,
    input  logic                 clr_err,
    output logic [1:0]           state,
    output logic                 locked,
    output logic                 err_word,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_THRESH + 1);
    localparam int SW = ((ERR_CNT_W > 6) ? ERR_CNT_W : 6) + 1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [2:0] poly_norm(input logic [2:0] sel);
        return (sel > 3'd4) ? 3'd0 : sel;
    endfunction

    function automatic logic [6:0] poly_len(input logic [2:0] sel);
        case (sel)
            3'd1:    return 7'd9;
            3'd2:    return 7'd15;
            3'd3:    return 7'd23;
            3'd4:    return 7'd31;
            default: return 7'd7;
        endcase
    endfunction

    function automatic logic [30:0] poly_mask(input logic [2:0] sel);
        case (sel)
            3'd1:    return 31'h0000_01ff;
            3'd2:    return 31'h0000_7fff;
            3'd3:    return 31'h007f_ffff;
            3'd4:    return 31'h7fff_ffff;
            default: return 31'h0000_007f;
        endcase
    endfunction

    function automatic logic feedback(input logic [30:0] s, input logic [2:0] sel);
        case (sel)
            3'd1:    return s[8] ^ s[4];
            3'd2:    return s[14] ^ s[13];
            3'd3:    return s[22] ^ s[17];
            3'd4:    return s[30] ^ s[27];
            default: return s[6] ^ s[5];
        endcase
    endfunction

    // Returns {next_state, word}; word bit 0 is the first bit produced.
    function automatic logic [DATA_W+30:0] lfsr_word(input logic [30:0] s, input logic [2:0] sel);
        logic [30:0]       t;
        logic [DATA_W-1:0] w;
        t = s;
        w = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w[i] = feedback(t, sel);
            t    = {t[29:0], w[i]} & poly_mask(sel);
        end
        return {t, w};
    endfunction

    function automatic logic [30:0] shift_in(input logic [30:0] s, input logic [DATA_W-1:0] d,
                                             input logic [2:0] sel);
        logic [30:0] t;
        t = s;
        for (int i = 0; i < DATA_W; i++) begin
            t = {t[29:0], d[i]} & poly_mask(sel);
        end
        return t;
    endfunction

    function automatic logic [5:0] popcount(input logic [DATA_W-1:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + 6'(d[i]);
        end
        return c;
    endfunction

    logic [2:0]           poly_n;
    logic [2:0]           poly_q;
    logic                 poly_chg;
    logic [30:0]          gen_s;
    logic [DATA_W+30:0]   gen_pack;
    logic                 inj_pend;
    logic                 xfer;
    logic                 load;
    logic                 inj_hit;

    logic [30:0]          chk_s;
    logic [30:0]          chk_s_d;
    chk_state_t           state_q;
    chk_state_t           state_d;
    logic [5:0]           fill_q;
    logic [5:0]           fill_d;
    logic [6:0]           fill_sum;
    logic [MW-1:0]        match_q;
    logic [MW-1:0]        match_d;
    logic [BW-1:0]        bad_q;
    logic [BW-1:0]        bad_d;
    logic [DATA_W+30:0]   pred_pack;
    logic [DATA_W-1:0]    pred;
    logic [30:0]          search_s;
    logic                 miss;
    logic                 count_err;
    logic [5:0]           err_bits;
    logic [SW-1:0]        err_sum;

    // Handshake: a word moves on a rising edge where gen_valid && gen_ready; gen_data is held
    // stable while gen_valid && !gen_ready. The checker side has no backpressure.
    assign poly_n   = poly_norm(poly_sel);
    assign poly_chg = (poly_n != poly_q);
    assign gen_pack = lfsr_word(gen_s, poly_q);
    assign xfer     = gen_valid && gen_ready;
    assign load     = en && (!gen_valid || gen_ready);
    assign inj_hit  = xfer && (inj_pend || inj_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            poly_q    <= poly_n;
            gen_s     <= poly_mask(poly_n);
            gen_valid <= 1'b0;
            gen_data  <= '0;
            inj_pend  <= 1'b0;
        end else if (poly_chg) begin
            // Drop the in-flight word so the first new word is from the new polynomial.
            poly_q    <= poly_n;
            gen_s     <= poly_mask(poly_n);
            gen_valid <= 1'b0;
            inj_pend  <= inj_pend || inj_err;
        end else begin
            gen_valid <= en;
            if (load) begin
                gen_s    <= gen_pack[DATA_W+30:DATA_W];
                gen_data <= gen_pack[DATA_W-1:0] ^ DATA_W'(inj_hit);
            end
            inj_pend <= (inj_pend || inj_err) && !(xfer && load);
        end
    end

    assign pred_pack = lfsr_word(chk_s, poly_q);
    assign pred      = pred_pack[DATA_W-1:0];
    assign search_s  = shift_in(chk_s, chk_data, poly_q);
    assign miss      = |(pred ^ chk_data);
    assign err_bits  = popcount(pred ^ chk_data);
    assign fill_sum  = 7'(fill_q) + 7'(DATA_W);

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        match_d   = match_q;
        bad_d     = bad_q;
        chk_s_d   = chk_s;
        count_err = 1'b0;
        if (poly_chg) begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
            bad_d   = '0;
            chk_s_d = '0;
        end else if (chk_valid) begin
            case (state_q)
                SEARCH: begin
                    chk_s_d = search_s;
                    if (fill_sum >= poly_len(poly_q)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_sum[5:0];
                    end
                end
                VERIFY: begin
                    // The checker free-runs on its own prediction once seeded.
                    chk_s_d   = pred_pack[DATA_W+30:DATA_W];
                    count_err = 1'b1;
                    if (miss) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                    end else if (match_q == MW'(LOCK_CNT - 1)) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    chk_s_d   = pred_pack[DATA_W+30:DATA_W];
                    count_err = 1'b1;
                    if (!miss) begin
                        bad_d = '0;
                    end else if (bad_q == BW'(LOSS_THRESH - 1)) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            fill_q  <= '0;
            match_q <= '0;
            bad_q   <= '0;
            chk_s   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            bad_q   <= bad_d;
            chk_s   <= chk_s_d;
        end
    end

    assign err_sum = SW'(err_cnt) + SW'(err_bits);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_word <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err_word <= count_err && miss;
            if (clr_err) begin
                err_cnt <= '0;
            end else if (count_err) begin
                if (err_sum > SW'({ERR_CNT_W{1'b1}})) begin
                    err_cnt <= '1;
                end else begin
                    err_cnt <= err_sum[ERR_CNT_W-1:0];
                end
            end
        end
    end

    assign state  = state_q;
    assign locked = (state_q == LOCKED);

endmodule
